sync_filter: RTL and testbench

SYNC_FILTER -- requirements
Module: sync_filter

---
 rtl/sync_filter.sv | 80 ++++++++
 tb/tb_sync_filter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sync_filter.sv
// Multi-channel synchroniser with a per-channel stability filter and optional
// rise/fall pulse outputs (compiled in when SYNC_FILTER_EDGE_EN is defined).
module sync_filter #(
    parameter int                    DATA_WIDTH = 1,
    parameter int                    DELAY      = 3,
    parameter int                    FILTER_LEN = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [DATA_WIDTH-1:0] rise_o,
    output logic [DATA_WIDTH-1:0] fall_o
);

    localparam int            CW       = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [DATA_WIDTH-1:0] chain [DELAY];
    logic [CW-1:0]         cnt   [DATA_WIDTH];
    logic [DATA_WIDTH-1:0] sync;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] load;

    assign sync = chain[DELAY-1];
    assign diff = sync ^ data_o;

    // A channel commits once its synchronised level has disagreed with
    // data_o for FILTER_LEN consecutive edges.
    always_comb begin
        load = '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            load[k] = diff[k] && (cnt[k] == CNT_LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DELAY; i++) begin
                chain[i] <= RESET_VAL;
            end
            for (int k = 0; k < DATA_WIDTH; k++) begin
                cnt[k] <= '0;
            end
            data_o <= RESET_VAL;
        end else begin
            chain[0] <= data_i;
            for (int i = 1; i < DELAY; i++) begin
                chain[i] <= chain[i-1];
            end
            for (int k = 0; k < DATA_WIDTH; k++) begin
                if (!diff[k] || load[k]) begin
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + CNT_ONE;
                end
            end
            data_o <= (data_o & ~load) | (sync & load);
        end
    end

`ifdef SYNC_FILTER_EDGE_EN
    // Pulses are registered alongside data_o so they line up with its new value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rise_o <= '0;
            fall_o <= '0;
        end else begin
            rise_o <= load & sync;
            fall_o <= load & ~sync;
        end
    end
`else
    assign rise_o = '0;
    assign fall_o = '0;
`endif

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter: a cycle table on a 4-channel instance plus
// hand sequences for latency, reset-mid-filter and FILTER_LEN=1 behaviour.
module tb_sync_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       da, dc;
    logic [3:0] db;
    logic       a_out, a_rise, a_fall;
    logic [3:0] b_out, b_rise, b_fall;
    logic       c_out, c_rise, c_fall;

    int checks   = 0;
    int failures = 0;

`ifdef SYNC_FILTER_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    sync_filter #(.DATA_WIDTH(1), .DELAY(3), .FILTER_LEN(4), .RESET_VAL(1'b0)) u_a (
        .clk_i(clk), .rst_i(rst), .data_i(da), .data_o(a_out), .rise_o(a_rise), .fall_o(a_fall));
    sync_filter #(.DATA_WIDTH(4), .DELAY(3), .FILTER_LEN(4), .RESET_VAL(4'b0000)) u_b (
        .clk_i(clk), .rst_i(rst), .data_i(db), .data_o(b_out), .rise_o(b_rise), .fall_o(b_fall));
    sync_filter #(.DATA_WIDTH(1), .DELAY(3), .FILTER_LEN(1), .RESET_VAL(1'b1)) u_c (
        .clk_i(clk), .rst_i(rst), .data_i(dc), .data_o(c_out), .rise_o(c_rise), .fall_o(c_fall));

    typedef struct {
        logic       rst;
        logic [3:0] din;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        int         n;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until the selected single-bit instance shows target; n counts edges
    // including the first one after the call. Gives up after 20 edges.
    task automatic measure(input int which, input logic target, output int n,
                           output logic early, output logic pulse);
        logic o, p;
        early = 1'b0;
        pulse = 1'b0;
        for (n = 1; n <= 20; n++) begin
            tick();
            o = (which == 0) ? a_out : c_out;
            p = (which == 0) ? (a_rise | a_fall) : (c_rise | c_fall);
            if (o == target) begin
                pulse = p;
                return;
            end
            early |= p;
        end
    endtask

    int   n;
    logic early, pulse;

    initial begin
        rst = 1'b1;
        da  = 1'b0;
        db  = 4'b0000;
        dc  = 1'b1;

        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2});
        tbl.push_back('{1'b0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 6});
        tbl.push_back('{1'b0, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 1});
        tbl.push_back('{1'b0, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 1});
        tbl.push_back('{1'b0, 4'b0101, 4'b1010, 4'b0000, 4'b0000, 6});
        tbl.push_back('{1'b0, 4'b0101, 4'b0101, 4'b0101, 4'b1010, 1});
        tbl.push_back('{1'b0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1});
        tbl.push_back('{1'b0, 4'b1101, 4'b0101, 4'b0000, 4'b0000, 3});
        tbl.push_back('{1'b0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 6});
        tbl.push_back('{1'b0, 4'b1101, 4'b0101, 4'b0000, 4'b0000, 6});
        tbl.push_back('{1'b0, 4'b1101, 4'b1101, 4'b1000, 4'b0000, 1});
        tbl.push_back('{1'b0, 4'b1101, 4'b1101, 4'b0000, 4'b0000, 2});

        foreach (tbl[r]) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                rst = tbl[r].rst;
                db  = tbl[r].din;
                tick();
                check($sformatf("b_out row%0d cyc%0d", r, c), b_out, tbl[r].out);
                check($sformatf("b_rise row%0d cyc%0d", r, c), b_rise, EDGE ? tbl[r].rise : 4'b0000);
                check($sformatf("b_fall row%0d cyc%0d", r, c), b_fall, EDGE ? tbl[r].fall : 4'b0000);
                check($sformatf("b_overlap row%0d cyc%0d", r, c), b_rise & b_fall, 4'b0000);
                if (r == 0) begin
                    check("a_out reset", a_out, 1'b0);
                    check("c_out reset", c_out, 1'b1);
                end
            end
        end

        // Single-channel 0->1 with full latency.
        da = 1'b1;
        measure(0, 1'b1, n, early, pulse);
        check("a latency", n, 7);
        check("a early pulse", early, 1'b0);
        check("a rise at change", pulse, EDGE);
        tick();
        check("a rise one cycle", a_rise, 1'b0);
        check("a out held", a_out, 1'b1);

        // Return to 0, then reset while the count sits at 2.
        da = 1'b0;
        repeat (10) tick();
        check("a back low", a_out, 1'b0);
        da = 1'b1;
        repeat (5) tick();
        check("a still low mid-filter", a_out, 1'b0);
        rst = 1'b1;
        tick();
        check("a out in reset", a_out, 1'b0);
        check("a rise in reset", a_rise, 1'b0);
        check("c out in reset", c_out, 1'b1);
        rst = 1'b0;
        measure(0, 1'b1, n, early, pulse);
        check("a latency after reset", n, 7);
        check("a no pulse after release", early, 1'b0);
        check("a rise after reset", pulse, EDGE);

        // FILTER_LEN=1 instance resetting to 1, falling input.
        dc = 1'b0;
        measure(1, 1'b0, n, early, pulse);
        check("c latency", n, 4);
        check("c early pulse", early, 1'b0);
        check("c fall at change", c_fall, EDGE);
        check("c rise at change", c_rise, 1'b0);
        tick();
        check("c fall one cycle", c_fall, 1'b0);
        check("c out held", c_out, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
